// File: rtl/muldiv_pkg.sv
// muldiv_pkg: RV32M funct3 codes, sequencer states and operand-signedness helpers
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    function automatic logic is_signed_a(input logic [2:0] f3);
        return f3 == F3_MULH || f3 == F3_MULHSU || f3 == F3_DIV || f3 == F3_REM;
    endfunction

    function automatic logic is_signed_b(input logic [2:0] f3);
        return f3 == F3_MULH || f3 == F3_DIV || f3 == F3_REM;
    endfunction

    function automatic logic is_div(input logic [2:0] f3);
        return f3 == F3_DIV || f3 == F3_DIVU || f3 == F3_REM || f3 == F3_REMU;
    endfunction

    function automatic logic is_rem(input logic [2:0] f3);
        return f3 == F3_REM || f3 == F3_REMU;
    endfunction

endpackage

// File: rtl/addsub_w.sv
// addsub_w: W-bit adder/subtractor shared by the multiply-add and divide-subtract steps
module addsub_w #(
    parameter int W = 33
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         sub_i,
    output logic [W-1:0] y_o
);
    assign y_o = a_i + (b_i ^ {W{sub_i}}) + {{(W-1){1'b0}}, sub_i};
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer (radix-2 shift-add / restoring divide)
// with sign correction, RISC-V divide special cases and a start/done handshake.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state_q, state_d;
    logic [2:0]        f3_q, f3_d;
    logic [XLEN-1:0]   m_q, m_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              negp_q, negp_d;
    logic              negr_q, negr_d;

    logic              sa, sb, accept, div_zero, div_ovf, special, is_div_q;
    logic [XLEN-1:0]   abs_a, abs_b, special_res, rem_fix, fix_res;
    logic [XLEN:0]     add_x, add_y, sum;
    logic [2*XLEN-1:0] mul_step, div_step, prod_fix;

    assign sa     = is_signed_a(funct3) && op_a[XLEN-1];
    assign sb     = is_signed_b(funct3) && op_b[XLEN-1];
    assign abs_a  = sa ? -op_a : op_a;
    assign abs_b  = sb ? -op_b : op_b;
    assign accept = start && (state_q == S_IDLE || state_q == S_DONE);

    assign div_zero    = op_b == '0;
    assign div_ovf     = (funct3 == F3_DIV || funct3 == F3_REM) && op_a == MIN_NEG && op_b == '1;
    assign special     = is_div(funct3) && (div_zero || div_ovf);
    assign special_res = div_zero ? (is_rem(funct3) ? op_a : '1) : (is_rem(funct3) ? '0 : op_a);

    // Multiply adds m to the product high half; divide subtracts m from {remainder, next dividend bit}.
    assign is_div_q = is_div(f3_q);
    assign add_x    = is_div_q ? prod_q[2*XLEN-1:XLEN-1] : {1'b0, prod_q[2*XLEN-1:XLEN]};
    assign add_y    = {1'b0, m_q};

    addsub_w #(.W(XLEN + 1)) u_addsub (
        .a_i   (add_x),
        .b_i   (add_y),
        .sub_i (is_div_q),
        .y_o   (sum)
    );

    assign mul_step = {prod_q[0] ? sum : add_x, prod_q[XLEN-1:1]};
    assign div_step = sum[XLEN] ? {prod_q[2*XLEN-2:0], 1'b0}
                                : {sum[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};

    // After division the high half holds the remainder and the low half the quotient.
    assign prod_fix = negp_q ? -prod_q : prod_q;
    assign rem_fix  = negr_q ? -prod_q[2*XLEN-1:XLEN] : prod_q[2*XLEN-1:XLEN];
    assign fix_res  = f3_q == F3_MUL ? prod_fix[XLEN-1:0]
                    : is_div_q ? (is_rem(f3_q) ? rem_fix : prod_fix[XLEN-1:0])
                    : prod_fix[2*XLEN-1:XLEN];

    always_comb begin
        state_d  = state_q;
        f3_d     = f3_q;
        m_d      = m_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        negp_d   = negp_q;
        negr_d   = negr_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: state_d = S_IDLE;
            S_CALC: begin
                prod_d  = is_div_q ? div_step : mul_step;
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = cnt_q == CNT_W'(XLEN - 1) ? S_FIX : S_CALC;
            end
            S_FIX: begin
                result_d = fix_res;
                state_d  = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (accept) begin
            f3_d     = funct3;
            cnt_d    = '0;
            negp_d   = sa ^ sb;
            negr_d   = sa;
            m_d      = is_div(funct3) ? abs_b : abs_a;
            prod_d   = {{XLEN{1'b0}}, is_div(funct3) ? abs_a : abs_b};
            state_d  = special ? S_DONE : S_CALC;
            result_d = special ? special_res : result_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            f3_q     <= '0;
            m_q      <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            negp_q   <= 1'b0;
            negr_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            f3_q     <= f3_d;
            m_q      <= m_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            negp_q   <= negp_d;
            negr_q   <= negr_d;
            result_q <= result_d;
        end
    end

    assign busy   = state_q == S_CALC || state_q == S_FIX;
    assign done   = state_q == S_DONE;
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: scoreboard bench for muldiv_seq against a plain-arithmetic RV32M model
module tb_muldiv_seq;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        busy, done;
    logic [31:0] result;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;
    exp_t scb[$];

    muldiv_seq #(.XLEN(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        if (f[2] && b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
        case (f)
            F3_MUL:    r = ua * ub;
            F3_MULH:   r = sa * sb;
            F3_MULHSU: r = sa * ub;
            F3_MULHU:  r = ua * ub;
            F3_DIV:    r = sa / sb;
            F3_DIVU:   r = ua / ub;
            F3_REM:    r = sa % sb;
            default:   r = ua % ub;
        endcase
        return (f == F3_MUL || f[2]) ? r[31:0] : r[63:32];
    endfunction

    function automatic int latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 32'd0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
        return 34;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset && done) begin
            if (scb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done got result %h at cycle %0d want no done", result, cyc);
            end else begin
                e = scb.pop_front();
                check("result", result, e.res);
                check("done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        funct3 = f;
        op_a   = a;
        op_b   = b;
        start  = 1'b1;
        scb.push_back('{model(f, a, b), cyc + latency(f, a, b)});
    endtask

    task automatic wait_all(input int exp_busy);
        int nb = 0;
        bit ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick();
            start = 1'b0;
            if (busy) nb++;
            if (scb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL timeout got %0d pending want 0", scb.size());
            scb.delete();
        end
        if (exp_busy >= 0) check("busy_cycles", nb, exp_busy);
    endtask

    task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        issue(f, a, b);
        wait_all(latency(f, a, b) - 1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit seen;
        repeat (3) tick();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", result, 32'd0);
        reset = 1'b0;
        tick();

        run(F3_MUL, 32'd7, 32'hFFFF_FFFD);
        run(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run(F3_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run(F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run(F3_DIV, 32'hFFFF_FFF9, 32'd2);
        run(F3_REM, 32'hFFFF_FFF9, 32'd2);
        run(F3_DIVU, 32'd7, 32'd2);
        run(F3_REMU, 32'd7, 32'd2);
        run(F3_DIV, 32'd5, 32'd0);
        run(F3_REMU, 32'd5, 32'd0);
        run(F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run(F3_REM, 32'h8000_0000, 32'hFFFF_FFFF);

        // A start pulse mid-calculation must not disturb the running multiply.
        issue(F3_MUL, 32'h0001_2345, 32'h0000_0F0F);
        repeat (10) begin
            tick();
            start = 1'b0;
        end
        funct3 = F3_MULHU;
        op_a   = 32'hDEAD_BEEF;
        op_b   = 32'h1234_5678;
        start  = 1'b1;
        wait_all(-1);

        // Back-to-back: second start issued in the DONE cycle of the first.
        issue(F3_DIVU, 32'd1000, 32'd9);
        seen = 1'b0;
        for (int k = 0; k < 60; k++) begin
            tick();
            start = 1'b0;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL b2b_first_done got none want done");
        end
        issue(F3_MUL, 32'hFFFF_FFF0, 32'd3);
        wait_all(-1);

        // Asynchronous reset in the middle of a calculation.
        issue(F3_MUL, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (15) begin
            tick();
            start = 1'b0;
        end
        reset = 1'b1;
        #1;
        check("async_reset_busy", 32'(busy), 32'd0);
        check("async_reset_done", 32'(done), 32'd0);
        check("async_reset_result", result, 32'd0);
        scb.delete();
        tick();
        tick();
        reset = 1'b0;
        tick();
        run(F3_DIVU, 32'd100, 32'd7);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  f;
            logic [31:0] a, b;
            f = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            run(f, a, b);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
